// File: rtl/vreg_fill_ctrl.sv
// vreg_fill_ctrl: moves one 40-bit vector register (5 x 8-bit lanes) between
// the vector register file and byte-wide data memory, one lane per memory beat.
module vreg_fill_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_store,
  input  logic [31:0] base_addr,
  input  logic [3:0]  vreg,
  input  logic [39:0] vreg_rdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [3:0]  vreg_sel,
  output logic [2:0]  vlane,
  output logic        WE_V,
  output logic [7:0]  DinV_8bit
);

  localparam int unsigned LANES  = 5;
  localparam int unsigned STRIDE = 1;
  localparam int unsigned LANE_W = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WB, DONE} state_t;

  state_t              state;
  logic [LANE_W-1:0]   lane;
  logic                op_q;
  logic [ADDR_W-1:0]   base_q;
  logic [3:0]          vreg_q;
  logic [39:0]         snap;
  logic [LANE_W-1:0]   next_lane;

  // Byte address of a lane, wrapping modulo 2^32.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LANE_W-1:0] l);
    return base + ADDR_W'(l) * ADDR_W'(STRIDE);
  endfunction

  // Select one lane byte of a 40-bit vector; out-of-range lanes read as zero.
  function automatic logic [BYTE_W-1:0] lane_byte(input logic [39:0] v,
                                                  input logic [LANE_W-1:0] l);
    logic [BYTE_W-1:0] b;
    b = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (l == LANE_W'(i)) b = v[i*BYTE_W +: BYTE_W];
    end
    return b;
  endfunction

  assign next_lane = lane + LANE_W'(1);

  // Hold decode in the start cycle (before the FSM leaves IDLE) and while moving lanes.
  assign stall = ((state == IDLE) && start) || (state == REQ) || (state == WB);

  // Sequencer: state, latches and registered outputs for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= '0;
      op_q      <= 1'b0;
      base_q    <= '0;
      vreg_q    <= '0;
      snap      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vreg_sel  <= '0;
      vlane     <= '0;
      WE_V      <= 1'b0;
      DinV_8bit <= '0;
    end else begin
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vreg_sel  <= '0;
      vlane     <= '0;
      WE_V      <= 1'b0;
      DinV_8bit <= '0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            op_q      <= op_store;
            base_q    <= base_addr;
            vreg_q    <= vreg;
            snap      <= op_store ? vreg_rdata : '0;
            lane      <= '0;
            state     <= REQ;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= op_store;
            mem_addr  <= base_addr;
            mem_wdata <= op_store ? vreg_rdata[BYTE_W-1:0] : '0;
          end
        end
        REQ: begin
          busy <= 1'b1;
          if (mem_ack && !op_q) begin
            state     <= WB;
            WE_V      <= 1'b1;
            vreg_sel  <= vreg_q;
            vlane     <= lane;
            DinV_8bit <= mem_rdata;
          end else if (mem_ack && (lane == LAST_LANE)) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (mem_ack) begin
            lane      <= next_lane;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= lane_addr(base_q, next_lane);
            mem_wdata <= lane_byte(snap, next_lane);
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= op_q;
            mem_addr  <= lane_addr(base_q, lane);
            mem_wdata <= op_q ? lane_byte(snap, lane) : '0;
          end
        end
        WB: begin
          busy <= 1'b1;
          if (lane == LAST_LANE) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            lane     <= next_lane;
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= lane_addr(base_q, next_lane);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vreg_fill_ctrl.sv
// Bench for vreg_fill_ctrl: directed loads/stores with a scoreboard of expected
// memory beats and lane writes, each stamped with its cycle relative to start.
module tb_vreg_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, op_store;
  logic [31:0] base_addr;
  logic [3:0]  vreg;
  logic [39:0] vreg_rdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        busy, stall, done, mem_req, mem_we, WE_V;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, DinV_8bit;
  logic [3:0]  vreg_sel;
  logic [2:0]  vlane;

  vreg_fill_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op_store(op_store),
    .base_addr(base_addr), .vreg(vreg), .vreg_rdata(vreg_rdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .stall(stall), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .vreg_sel(vreg_sel),
    .vlane(vlane), .WE_V(WE_V), .DinV_8bit(DinV_8bit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;

  // Memory model: bytes 11 22 33 44 55 at 0x100..0x104; ack can be held off
  // for delay_n cycles on one address.
  logic        ack_on = 1'b0;
  logic [31:0] delay_addr = 32'h0000_0F00;
  int          delay_n = 0;
  int          same_cnt = 0;
  logic [31:0] ld_off;

  always @(posedge clk) begin
    if (mem_req && mem_addr == delay_addr) same_cnt <= same_cnt + 1;
    else same_cnt <= 0;
  end

  assign mem_ack   = ack_on && !(mem_addr == delay_addr && same_cnt < delay_n);
  assign ld_off    = mem_addr - 32'h100;
  assign mem_rdata = (ld_off < 32'd5) ? 8'(8'h11 * (ld_off + 32'd1)) : 8'h00;

  typedef struct { int rel; logic [31:0] addr; logic we; logic [7:0] data; } beat_t;
  typedef struct { int rel; logic [3:0] sel; logic [2:0] lane; logic [7:0] data; } wr_t;
  beat_t beat_q[$];
  wr_t   wr_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, stall, done, mem_req, mem_we, mem_addr, mem_wdata,
                vreg_sel, vlane, WE_V, DinV_8bit});
  endfunction

  // Scoreboard: every completed beat and every lane write must match the next expectation.
  always @(negedge clk) begin
    beat_t b;
    wr_t   w;
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      chk("beat_pending", 64'(beat_q.size() > 0), 64'd1);
      if (beat_q.size() > 0) begin
        b = beat_q.pop_front();
        chk("beat_cycle", 64'(cyc - start_cyc), 64'(b.rel));
        chk("beat_addr_we_data", 64'({mem_addr, mem_we, mem_wdata}),
            64'({b.addr, b.we, b.data}));
      end
    end
    if (WE_V === 1'b1) begin
      chk("write_pending", 64'(wr_q.size() > 0), 64'd1);
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        chk("write_cycle", 64'(cyc - start_cyc), 64'(w.rel));
        chk("write_sel_lane_data", 64'({vreg_sel, vlane, DinV_8bit}),
            64'({w.sel, w.lane, w.data}));
      end
    end
  end

  // One transfer: model its timing, push expectations, drive start, check stall/done.
  task automatic run_xfer(input logic op, input logic [31:0] base, input logic [3:0] vr,
                          input logic [39:0] rd, input logic [31:0] dly_addr, input int dly,
                          input int stray_rel, input int abort_rel);
    int          t;
    int          exp_done;
    bit          seen;
    logic [31:0] a;
    beat_t       b;
    wr_t         w;
    delay_addr = dly_addr;
    delay_n    = dly;
    t = 1;
    for (int i = 0; i < 5; i++) begin
      a = base + 32'(i);
      if (a == dly_addr) t += dly;
      b = '{t, a, op, op ? rd[i*8 +: 8] : 8'h00};
      if (t <= abort_rel) beat_q.push_back(b);
      if (!op) begin
        w = '{t + 1, vr, 3'(i), 8'(8'h11 * (i + 1))};
        if (t + 1 <= abort_rel) wr_q.push_back(w);
        t += 2;
      end else begin
        t += 1;
      end
    end
    exp_done = t;

    @(posedge clk); #1;
    start = 1'b1; op_store = op; base_addr = base; vreg = vr; vreg_rdata = rd;
    ack_on = 1'b1;
    start_cyc = cyc;
    seen = 1'b0;
    for (int rel = 0; rel < 60 && !seen; rel++) begin
      @(negedge clk);
      chk("stall", 64'(stall), 64'(rel < exp_done));
      if (done === 1'b1) begin
        chk("done_cycle", 64'(rel), 64'(exp_done));
        seen = 1'b1;
      end
      if (rel == abort_rel) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; ack_on = 1'b0;
        @(negedge clk);
        chk("abort_outputs_zero", outs(), 64'd0);
        chk("abort_beats_left", 64'(beat_q.size()), 64'd0);
        chk("abort_writes_left", 64'(wr_q.size()), 64'd0);
        return;
      end
      @(posedge clk); #1;
      start = (rel + 1 == stray_rel);
      vreg_rdata = 40'({$urandom, $urandom});
    end
    start  = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    chk("idle_after_done", 64'({busy, done, mem_req, WE_V}), 64'd0);
    chk("beats_left", 64'(beat_q.size()), 64'd0);
    chk("writes_left", 64'(wr_q.size()), 64'd0);
    ack_on = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_store = 1'b0; base_addr = '0; vreg = '0; vreg_rdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outputs_zero", outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load, zero-wait, vreg 3 at 0x100.
    run_xfer(1'b0, 32'h100, 4'd3, 40'h0, 32'h0000_0F00, 0, -1, 1000);
    // Store snapshot AABBCCDDEE to 0x200, vreg_rdata scrambled after start.
    run_xfer(1'b1, 32'h200, 4'd5, 40'hAA_BBCC_DDEE, 32'h0000_0F00, 0, -1, 1000);
    // Load with lane 2 ack held off for 3 cycles.
    run_xfer(1'b0, 32'h100, 4'd7, 40'h0, 32'h102, 3, -1, 1000);

    // Stray acks while idle must not start anything.
    ack_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ack_idle", outs(), 64'd0);
    end
    ack_on = 1'b0;

    // Wrapping store with a stray start pulse while in REQ.
    run_xfer(1'b1, 32'hFFFF_FFFE, 4'd1, 40'h01_0203_0405, 32'h0000_0F00, 0, 2, 1000);

    // Load aborted by reset in WB of lane 1, then a clean load.
    run_xfer(1'b0, 32'h100, 4'd9, 40'h0, 32'h0000_0F00, 0, -1, 4);
    run_xfer(1'b0, 32'h100, 4'd2, 40'h0, 32'h0000_0F00, 0, -1, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
